// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Shared UART definitions: transmitter state encoding, line levels and the
// default oversampling ratio (also used by the baud-rate generator), plus a
// helper for index-register widths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    localparam int unsigned UART_OVERSAMPLE = 16;

    // Width of an index over n items; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
`timescale 1ns/1ps
// uart_tx_scheduler_if
// Request/grant and line bundle between the byte requesters and the shared
// UART transmitter.
//   i_req   [N_REQ]            level request, one bit per requester
//   i_data  [N_REQ*DATA_BITS]  requester k's byte at [k*DATA_BITS +: DATA_BITS]
//   o_grant [N_REQ]            one-hot, one-cycle pulse when a byte is taken
//   o_owner [idx]              index of the requester being sent
//   o_busy                     frame in progress
//   o_tx                       serial line, idle high
// master: requester side; slave: transmitter side.
interface uart_tx_scheduler_if #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned DATA_BITS = 8
);
    import uart_pkg::*;

    localparam int unsigned OWNER_W = idx_width(N_REQ);

    logic [N_REQ-1:0]           i_req;
    logic [N_REQ*DATA_BITS-1:0] i_data;
    logic [N_REQ-1:0]           o_grant;
    logic [OWNER_W-1:0]         o_owner;
    logic                       o_busy;
    logic                       o_tx;

    modport master (
        output i_req, i_data,
        input  o_grant, o_owner, o_busy, o_tx
    );

    modport slave (
        input  i_req, i_data,
        output o_grant, o_owner, o_busy, o_tx
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`timescale 1ns/1ps
// rr_arbiter
// Combinational round-robin pick: scans req starting at ptr, wrapping
// modulo N_REQ, and returns the first set bit.
//   req   [N_REQ]  request vector
//   ptr   [idx]    highest-priority position
//   grant [N_REQ]  one-hot winner (zero when no request)
//   idx   [idx]    winner index
//   valid          any request present
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned k;
        k     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler
// Shares one UART TX line between N_REQ byte requesters. A round-robin
// arbiter picks a requester while idle; its byte is latched, granted with a
// one-cycle pulse and sent LSB first as 8N1 (or 8E1), paced by a 16x tick.
//   i_clock  system clock
//   i_reset  synchronous, active-low reset
//   i_tick   single-cycle oversampling strobe
//   bus      uart_tx_scheduler_if.slave (i_req, i_data, o_grant, o_owner,
//            o_busy, o_tx); all outputs registered
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    uart_tx_scheduler_if.slave bus
);

    localparam int unsigned IDX_W  = idx_width(N_REQ);
    localparam int unsigned TICK_W = idx_width(OVERSAMPLE);
    localparam int unsigned BIT_W  = idx_width((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_state_t          state, next_state;
    logic [TICK_W-1:0]    tick_cnt, tick_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     rr_ptr, rr_next;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity, parity_next;
`endif

    logic [N_REQ-1:0]     arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic [DATA_BITS-1:0] pick_data;

    logic                 tx_q, tx_next;
    logic                 busy_q, busy_next;
    logic [N_REQ-1:0]     grant_q, grant_next;
    logic [IDX_W-1:0]     owner_q, owner_next;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (bus.i_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Winner's byte, selected by the one-hot grant.
    always_comb begin
        pick_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (arb_grant[k]) begin
                pick_data = bus.i_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rr_ptr    <= '0;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            rr_ptr    <= rr_next;
`ifdef UART_TX_PARITY_EN
            parity    <= parity_next;
`endif
        end
    end

    // Next-state logic: arbitration in IDLE, bit timing everywhere else.
    always_comb begin
        next_state = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        rr_next    = rr_ptr;
        bit_end    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity;
`endif

        if (state != IDLE && i_tick) begin
            if (tick_cnt == TICK_LAST) begin
                tick_next = '0;
                bit_end   = 1'b1;
            end else begin
                tick_next = tick_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                tick_next = '0;
                bit_next  = '0;
                if (arb_valid) begin
                    next_state = START;
                    shift_next = pick_data;
                    rr_next    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^pick_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    next_state = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (bit_end) begin
                    next_state = STOP;
                end
`else
                next_state = IDLE;
`endif
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        next_state = IDLE;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: computed from the next state so the registered line
    // level lines up with the registered state.
    always_comb begin
        grant_next = '0;
        owner_next = owner_q;
        busy_next  = (next_state != IDLE);
        if (state == IDLE && arb_valid) begin
            grant_next = arb_grant;
            owner_next = arb_idx;
        end
        case (next_state)
            START:   tx_next = UART_START_LEVEL;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            tx_q    <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
            grant_q <= '0;
            owner_q <= '0;
        end else begin
            tx_q    <= tx_next;
            busy_q  <= busy_next;
            grant_q <= grant_next;
            owner_q <= owner_next;
        end
    end

    assign bus.o_tx    = tx_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_grant = grant_q;
    assign bus.o_owner = owner_q;

endmodule
